mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 multiplexer datapath between two requesters (A and B). It registers the mux select `s` and per-requester grants so that at most one source drives `out` at a time. It enforces a bounded hold time under contention, so neither requester can starve the other. It sits directly in front of the 2:1 mux in the lab datapath and replaces a hand-driven select.

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/mux_rr_arbiter_mux2.sv | 13 +
 rtl/mux_rr_arbiter.sv | 85 ++++++++
 tb/tb_mux_rr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and select encodings for the round-robin 2:1 mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_mux2.sv
// Plain 2:1 datapath mux; s=0 passes a, s=1 passes b.
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out
);

  assign out = s ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 mux, with a bounded
// hold time per requester while the other one is waiting.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [1:0]       dbg_state
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] hold_cnt;
  logic          last;

  // Handshake: a requester holds req_x high while it wants the datapath; it
  // owns out on every cycle its gnt_x is high and must drop req_x to release.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last == SEL_B)) nxt = GRANT_A;
        else if (req_b)                         nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!req_a)                             nxt = req_b ? GRANT_B : IDLE;
        else if (req_b && hold_cnt == HOLD_LAST) nxt = GRANT_B;
      end
      GRANT_B: begin
        if (!req_b)                             nxt = req_a ? GRANT_A : IDLE;
        else if (req_a && hold_cnt == HOLD_LAST) nxt = GRANT_A;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= SEL_B;
      s        <= SEL_A;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
    end else begin
      state <= nxt;
      gnt_a <= (nxt == GRANT_A);
      gnt_b <= (nxt == GRANT_B);
      if (nxt != IDLE && nxt != state) begin
        hold_cnt <= '0;
        last     <= (nxt == GRANT_B) ? SEL_B : SEL_A;
        s        <= (nxt == GRANT_B) ? SEL_B : SEL_A;
      end else if (nxt != IDLE && hold_cnt != HOLD_LAST) begin
        // Saturating, so an uncontested owner is cut only once a rival appears.
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

  assign out_valid = gnt_a | gnt_b;
  assign dbg_state = state;

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .s   (s),
    .out (out)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: one instance with MAX_HOLD=4 and one with MAX_HOLD=1,
// driven by the same stimulus, each checked against its own expected queue.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] a = 8'h5a;
  logic [7:0] b = 8'ha5;

  logic       gnt_a4, gnt_b4, s4, out_valid4;
  logic [7:0] out4;
  logic [1:0] dbg_state4;
  logic       gnt_a1, gnt_b1, s1, out_valid1;
  logic [7:0] out1;
  logic [1:0] dbg_state1;

  int total = 0;
  int bad = 0;

  // entry = {gnt_a, gnt_b, s, out_valid, out}
  logic [11:0] exp_q[$];
  logic [11:0] exp1_q[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a4), .gnt_b(gnt_b4), .s(s4), .out(out4),
    .out_valid(out_valid4), .dbg_state(dbg_state4)
  );

  mux_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .s(s1), .out(out1),
    .out_valid(out_valid1), .dbg_state(dbg_state1)
  );

  function automatic logic [11:0] mk(input logic ga, input logic gb, input logic sel,
                                     input logic ov, input logic [7:0] o);
    return {ga, gb, sel, ov, o};
  endfunction

  // Scoreboard: one entry per clock edge, popped just after that edge.
  always @(posedge clk) begin
    logic [11:0] got;
    logic [11:0] exp;
    #1;
    if (rst_n) begin
      total++;
      if ((gnt_a4 & gnt_b4) !== 1'b0 || out4 !== (s4 ? b : a)) begin
        bad++;
        $display("FAIL inv_dut4 ga=%b gb=%b s=%b out=%h a=%h b=%h", gnt_a4, gnt_b4, s4, out4, a, b);
      end
      total++;
      if ((gnt_a1 & gnt_b1) !== 1'b0 || out1 !== (s1 ? b : a)) begin
        bad++;
        $display("FAIL inv_dut1 ga=%b gb=%b s=%b out=%h a=%h b=%h", gnt_a1, gnt_b1, s1, out1, a, b);
      end
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {gnt_a4, gnt_b4, s4, out_valid4, out4};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL sb_dut4 t=%0t got=%h exp=%h", $time, got, exp);
        end
      end
      if (exp1_q.size() > 0) begin
        exp = exp1_q.pop_front();
        got = {gnt_a1, gnt_b1, s1, out_valid1, out1};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL sb_dut1 t=%0t got=%h exp=%h", $time, got, exp);
        end
      end
    end
  end

  task automatic drive(input logic ra, input logic rb, input logic [7:0] av,
                       input logic [7:0] bv, input logic [11:0] e4, input logic [11:0] e1);
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    a = av;
    b = bv;
    exp_q.push_back(e4);
    exp1_q.push_back(e1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt_a4, gnt_b4, s4, out_valid4, out4, dbg_state4} !== {4'b0000, 8'h5a, 2'b00}) begin
      bad++;
      $display("FAIL reset_dut4 got=%b_%h_%b exp=0000_5a_00", {gnt_a4, gnt_b4, s4, out_valid4}, out4, dbg_state4);
    end
    total++;
    if ({gnt_a1, gnt_b1, s1, out_valid1, out1, dbg_state1} !== {4'b0000, 8'h5a, 2'b00}) begin
      bad++;
      $display("FAIL reset_dut1 got=%b_%h_%b exp=0000_5a_00", {gnt_a1, gnt_b1, s1, out_valid1}, out1, dbg_state1);
    end
    rst_n = 1'b1;
  endtask

  // Uncontested A keeps its grant well past MAX_HOLD.
  task automatic test_single_a();
    logic [11:0] e;
    e = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 8'h01, 8'h00, e, e);
    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    drive(1'b0, 1'b0, 8'h01, 8'h00, e, e);
  endtask

  task automatic test_contention();
    logic [7:0]  av, bv;
    logic [11:0] e4, e1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      e4 = (((i / 4) % 2) == 0) ? mk(1'b1, 1'b0, 1'b0, 1'b1, av) : mk(1'b0, 1'b1, 1'b1, 1'b1, bv);
      e1 = ((i % 2) == 0)       ? mk(1'b1, 1'b0, 1'b0, 1'b1, av) : mk(1'b0, 1'b1, 1'b1, 1'b1, bv);
      drive(1'b1, 1'b1, av, bv, e4, e1);
    end
    av = 8'h3c;
    bv = 8'hc3;
    drive(1'b0, 1'b0, av, bv, mk(1'b0, 1'b0, 1'b0, 1'b0, av), mk(1'b0, 1'b0, 1'b1, 1'b0, bv));
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    e = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    drive(1'b0, 1'b1, 8'h11, 8'h22, e, e);
    e = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h33);
    drive(1'b1, 1'b0, 8'h33, 8'h44, e, e);
    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    drive(1'b0, 1'b0, 8'h55, 8'h66, e, e);
  endtask

  task automatic test_reset_mid_b();
    logic [11:0] ea, eb;
    do_reset();
    eb = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h02);
    ea = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h01, 8'h02, eb, eb);
    drive(1'b1, 1'b1, 8'h01, 8'h02, eb, ea);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    #1;
    total++;
    if ({gnt_a4, gnt_b4, s4, out_valid4, out4, dbg_state4} !== {4'b0000, 8'h01, 2'b00}) begin
      bad++;
      $display("FAIL async_rst_dut4 got=%b_%h_%b exp=0000_01_00", {gnt_a4, gnt_b4, s4, out_valid4}, out4, dbg_state4);
    end
    total++;
    if ({gnt_a1, gnt_b1, s1, out_valid1} !== 4'b0000) begin
      bad++;
      $display("FAIL async_rst_dut1 got=%b exp=0000", {gnt_a1, gnt_b1, s1, out_valid1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h01, 8'h02, ea, ea);
    drive(1'b1, 1'b1, 8'h01, 8'h02, ea, eb);
    drive(1'b0, 1'b0, 8'h01, 8'h02, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h01), mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h02));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_back_to_back();
    test_reset_mid_b();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left4=%0d left1=%0d exp=0", exp_q.size(), exp1_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
